// File: rtl/llc_rr_fifo_bank.sv
// llc_rr_fifo_bank: NUM_CH independent FIFOs merged onto one valid/ready
// output by a round-robin arbiter with a grant lock held while stalled.
module llc_rr_fifo_bank #(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int AFULL_TH     = DEPTH - 1,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            flush_i,
    input  logic [NUM_CH-1:0]            in_valid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
    output logic [NUM_CH-1:0]            in_ready_o,
    output logic                         out_valid_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic [CH_W-1:0]              out_ch_o,
    input  logic                         out_ready_i,
    output logic [NUM_CH*CNT_W-1:0]      usage_o,
    output logic [NUM_CH-1:0]            empty_o,
    output logic [NUM_CH-1:0]            afull_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (NUM_CH < 1) begin : g_err_ch
        $error("NUM_CH must be >= 1");
    end
    if (DEPTH < 1) begin : g_err_depth
        $error("DEPTH must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_err_dw
        $error("DATA_WIDTH must be >= 1");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_err_afull
        $error("AFULL_TH must be in 1..DEPTH");
    end

    logic [CNT_W-1:0]      cnt_q [NUM_CH];
    logic [CNT_W-1:0]      cnt_d [NUM_CH];
    logic [PTR_W-1:0]      rd_q  [NUM_CH];
    logic [PTR_W-1:0]      rd_d  [NUM_CH];
    logic [PTR_W-1:0]      wr_q  [NUM_CH];
    logic [PTR_W-1:0]      wr_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];

    logic            lock_q, lock_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic [CH_W-1:0] last_q, last_d;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] ft_cand;
    logic [NUM_CH-1:0] we;
    logic [CH_W-1:0]   grant;
    logic              gvalid;
    logic              handshake;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-channel status from registered counts only, plus eligibility.
    always_comb begin
        in_ready_o = '0;
        empty_o    = '0;
        afull_o    = '0;
        usage_o    = '0;
        ft_cand    = '0;
        elig       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready_o[c] = cnt_q[c] < CNT_W'(DEPTH);
            empty_o[c]    = cnt_q[c] == '0;
            afull_o[c]    = cnt_q[c] >= CNT_W'(AFULL_TH);
            usage_o[c*CNT_W +: CNT_W] = cnt_q[c];
            ft_cand[c]    = FALL_THROUGH && (cnt_q[c] == '0)
                            && in_valid_i[c];
            elig[c]       = (cnt_q[c] != '0) || ft_cand[c];
        end
    end

    // Locked channel wins; otherwise scan from the one after last_q.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx    = '0;
        grant  = '0;
        gvalid = 1'b0;
        if (lock_q) begin
            grant  = lock_ch_q;
            gvalid = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_CH; i++) begin
                idx = CH_W'((32'(last_q) + i) % NUM_CH);
                if (!gvalid && elig[idx]) begin
                    gvalid = 1'b1;
                    grant  = idx;
                end
            end
        end
    end

    // Output mux: bypassed input for a fall-through grant, else FIFO head.
    always_comb begin
        out_valid_o = gvalid;
        out_ch_o    = gvalid ? grant : '0;
        out_data_o  = '0;
        if (gvalid) begin
            if (ft_cand[grant]) begin
                out_data_o = in_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                out_data_o = mem_q[grant][rd_q[grant]];
            end
        end
    end

    // Next-state for counts, pointers, lock and round-robin pointer.
    always_comb begin
        logic bypass;
        logic pop_c;
        logic pop_mem;
        logic push;
        bypass    = 1'b0;
        pop_c     = 1'b0;
        pop_mem   = 1'b0;
        push      = 1'b0;
        we        = '0;
        handshake = gvalid && out_ready_i;
        for (int c = 0; c < NUM_CH; c++) begin
            pop_c   = handshake && (grant == CH_W'(c));
            bypass  = pop_c && ft_cand[c];
            pop_mem = pop_c && !ft_cand[c];
            push    = in_valid_i[c] && in_ready_o[c] && !bypass;
            we[c]   = push && !flush_i[c];
            cnt_d[c] = cnt_q[c] + CNT_W'(push) - CNT_W'(pop_mem);
            wr_d[c]  = push ? ptr_inc(wr_q[c]) : wr_q[c];
            rd_d[c]  = pop_mem ? ptr_inc(rd_q[c]) : rd_q[c];
            if (flush_i[c]) begin
                cnt_d[c] = '0;
                wr_d[c]  = '0;
                rd_d[c]  = '0;
            end
        end
        lock_d    = gvalid && !out_ready_i && !flush_i[grant];
        lock_ch_d = lock_d ? grant : '0;
        last_d    = handshake ? grant : last_q;
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            last_q    <= CH_W'(NUM_CH - 1);
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                rd_q[c]  <= '0;
                wr_q[c]  <= '0;
            end
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            last_q    <= last_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
                rd_q[c]  <= rd_d[c];
                wr_q[c]  <= wr_d[c];
            end
        end
    end

    // Storage array, written only on accepted, non-flushed pushes.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (we[c]) begin
                mem_q[c][wr_q[c]] <= in_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifndef SYNTHESIS
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
        a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
            cnt_q[c] <= CNT_W'(DEPTH));
        a_push_rdy: assert property (@(posedge clk_i) disable iff (!rst_ni)
            we[c] |-> in_ready_o[c]);
    end
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i[out_ch_o])
        |=> (out_valid_o && $stable(out_data_o)));
`endif

endmodule

// File: tb/tb_llc_rr_fifo_bank.sv
// tb_llc_rr_fifo_bank: table-driven fills, scoreboard-checked drains,
// plus a DEPTH=3 fall-through instance for wrap and bypass cases.
module tb_llc_rr_fifo_bank;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_ni;

    logic [3:0]   a_flush, a_in_valid, a_in_ready, a_empty, a_afull;
    logic [127:0] a_in_data;
    logic         a_out_valid, a_out_ready;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_ch;
    logic [11:0]  a_usage;

    logic [3:0]   b_flush, b_in_valid, b_in_ready, b_empty, b_afull;
    logic [127:0] b_in_data;
    logic         b_out_valid, b_out_ready;
    logic [31:0]  b_out_data;
    logic [1:0]   b_out_ch;
    logic [7:0]   b_usage;

    llc_rr_fifo_bank u_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_data_i(a_in_data),
        .in_ready_o(a_in_ready), .out_valid_o(a_out_valid),
        .out_data_o(a_out_data), .out_ch_o(a_out_ch),
        .out_ready_i(a_out_ready), .usage_o(a_usage),
        .empty_o(a_empty), .afull_o(a_afull)
    );

    llc_rr_fifo_bank #(.DEPTH(3), .FALL_THROUGH(1'b1)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_data_i(b_in_data),
        .in_ready_o(b_in_ready), .out_valid_o(b_out_valid),
        .out_data_o(b_out_data), .out_ch_o(b_out_ch),
        .out_ready_i(b_out_ready), .usage_o(b_usage),
        .empty_o(b_empty), .afull_o(b_afull)
    );

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        vb;
        logic [31:0] usage;
        logic        afull;
        logic        rdy;
    } vec_t;
    vec_t fill[10];

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];
    logic [31:0] bq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] au(input int c);
        return 32'(a_usage[c*3 +: 3]);
    endfunction

    function automatic logic [31:0] bu(input int c);
        return 32'(b_usage[c*2 +: 2]);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic a_drive(input int ch, input logic [31:0] d);
        sb_t e;
        a_in_valid[ch] = 1'b1;
        a_in_data[ch*32 +: 32] = d;
        e.ch = 2'(ch);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic sb_flush(input int ch);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].ch == 2'(ch)) sb.delete(i);
    endtask

    task automatic a_pop_check(input string name, input int exp_ch);
        int k;
        logic [31:0] exp_d;
        a_out_ready = 1'b1;
        #1;
        chk({name, ".valid"}, 32'(a_out_valid), 1);
        chk({name, ".ch"}, 32'(a_out_ch), exp_ch);
        k = -1;
        foreach (sb[i]) if (k < 0 && sb[i].ch == a_out_ch) k = i;
        if (k < 0) begin
            n_total++;
            $display("FAIL %s.data: got 0x%0h expected none", name, a_out_data);
        end else begin
            exp_d = sb[k].data;
            sb.delete(k);
            chk({name, ".data"}, a_out_data, exp_d);
        end
        step();
    endtask

    task automatic apply_fill(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            a_drive(fill[i].ch, fill[i].data);
            #1;
            chk($sformatf("fill%0d.lat", i), 32'(a_out_valid), 32'(fill[i].vb));
            step();
            a_in_valid = '0;
            #1;
            chk($sformatf("fill%0d.usage", i), au(fill[i].ch), fill[i].usage);
            chk($sformatf("fill%0d.afull", i),
                32'(a_afull[fill[i].ch]), 32'(fill[i].afull));
            chk($sformatf("fill%0d.rdy", i),
                32'(a_in_ready[fill[i].ch]), 32'(fill[i].rdy));
        end
    endtask

    initial begin
        int rr_exp[6];
        logic [31:0] e;
        rr_exp = '{0, 1, 3, 0, 1, 3};
        fill[0] = '{2, 32'hA0, 1'b0, 1, 1'b0, 1'b1};
        fill[1] = '{2, 32'hA1, 1'b1, 2, 1'b0, 1'b1};
        fill[2] = '{2, 32'hA2, 1'b1, 3, 1'b1, 1'b1};
        fill[3] = '{2, 32'hA3, 1'b1, 4, 1'b1, 1'b0};
        fill[4] = '{0, 32'h30, 1'b0, 1, 1'b0, 1'b1};
        fill[5] = '{0, 32'h31, 1'b1, 2, 1'b0, 1'b1};
        fill[6] = '{1, 32'h40, 1'b1, 1, 1'b0, 1'b1};
        fill[7] = '{1, 32'h41, 1'b1, 2, 1'b0, 1'b1};
        fill[8] = '{3, 32'h60, 1'b1, 1, 1'b0, 1'b1};
        fill[9] = '{3, 32'h61, 1'b1, 2, 1'b0, 1'b1};

        rst_ni = 1'b0;
        a_flush = '0; a_in_valid = '0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = '0; b_in_valid = '0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        chk("rst.rdy", 32'(a_in_ready), 32'hF);
        chk("rst.empty", 32'(a_empty), 32'hF);
        chk("rst.valid", 32'(a_out_valid), 0);
        chk("rst.usage", 32'(a_usage), 0);
        chk("rst.afull", 32'(a_afull), 0);
        chk("rst.data", a_out_data, 0);
        chk("rst.ch", 32'(a_out_ch), 0);
        chk("rst.b_empty", 32'(b_empty), 32'hF);
        step();

        apply_fill(0, 3);
        for (int i = 0; i < 4; i++) a_pop_check($sformatf("drain%0d", i), 2);
        #1;
        chk("drain.idle", 32'(a_out_valid), 0);
        chk("drain.usage", au(2), 0);
        a_out_ready = 1'b0;

        apply_fill(4, 9);
        for (int i = 0; i < 6; i++) a_pop_check($sformatf("rr%0d", i), rr_exp[i]);
        #1;
        chk("rr.idle", 32'(a_out_valid), 0);
        a_out_ready = 1'b0;

        a_drive(1, 32'h11);
        step();
        a_in_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) a_drive(0, 32'h22);
            #1;
            chk($sformatf("lock%0d.valid", k), 32'(a_out_valid), 1);
            chk($sformatf("lock%0d.ch", k), 32'(a_out_ch), 1);
            chk($sformatf("lock%0d.data", k), a_out_data, 32'h11);
            step();
            a_in_valid = '0;
        end
        a_pop_check("lock.rel1", 1);
        a_pop_check("lock.rel0", 0);
        #1;
        chk("lock.idle", 32'(a_out_valid), 0);
        a_out_ready = 1'b0;

        for (int i = 0; i < 4; i++) begin
            a_drive(0, 32'h80 + 32'(i));
            step();
            a_in_valid = '0;
        end
        #1;
        chk("fl.lockch", 32'(a_out_ch), 0);
        a_flush[0] = 1'b1;
        a_in_valid[0] = 1'b1;
        a_in_data[31:0] = 32'h99;
        step();
        a_flush = '0;
        a_in_valid = '0;
        sb_flush(0);
        #1;
        chk("fl.usage0", au(0), 0);
        chk("fl.empty0", 32'(a_empty[0]), 1);
        chk("fl.rdy0", 32'(a_in_ready[0]), 1);
        chk("fl.valid", 32'(a_out_valid), 0);

        a_drive(1, 32'h77);
        a_drive(0, 32'h88);
        step();
        a_in_valid = '0;
        #1;
        chk("fl2.ch", 32'(a_out_ch), 1);
        a_flush[0] = 1'b1;
        a_in_valid[0] = 1'b1;
        a_in_data[31:0] = 32'h99;
        step();
        a_flush = '0;
        a_in_valid = '0;
        sb_flush(0);
        #1;
        chk("fl2.usage0", au(0), 0);
        chk("fl2.usage1", au(1), 1);
        chk("fl2.data1", a_out_data, 32'h77);
        a_pop_check("fl2.pop1", 1);
        #1;
        chk("fl2.idle", 32'(a_out_valid), 0);
        chk("fl2.sb", sb.size(), 0);
        a_out_ready = 1'b0;

        b_in_valid[0] = 1'b1;
        b_in_data[31:0] = 32'h100;
        bq.push_back(32'h100);
        step();
        b_in_valid = '0;
        for (int i = 0; i < 10; i++) begin
            b_out_ready = 1'b1;
            b_in_valid[0] = 1'b1;
            b_in_data[31:0] = 32'h101 + 32'(i);
            bq.push_back(32'h101 + 32'(i));
            #1;
            e = bq.pop_front();
            chk($sformatf("wrap%0d.valid", i), 32'(b_out_valid), 1);
            chk($sformatf("wrap%0d.ch", i), 32'(b_out_ch), 0);
            chk($sformatf("wrap%0d.data", i), b_out_data, e);
            chk($sformatf("wrap%0d.usage", i), bu(0), 1);
            step();
        end
        b_in_valid = '0;
        #1;
        e = bq.pop_front();
        chk("wrap.last", b_out_data, e);
        step();
        #1;
        chk("wrap.usage", bu(0), 0);
        chk("wrap.idle", 32'(b_out_valid), 0);

        b_in_valid[3] = 1'b1;
        b_in_data[127:96] = 32'h55;
        #1;
        chk("ft.valid", 32'(b_out_valid), 1);
        chk("ft.ch", 32'(b_out_ch), 3);
        chk("ft.data", b_out_data, 32'h55);
        step();
        b_in_valid = '0;
        #1;
        chk("ft.usage3", bu(3), 0);
        chk("ft.empty", 32'(b_empty), 32'hF);
        chk("ft.idle", 32'(b_out_valid), 0);

        b_out_ready = 1'b0;
        b_in_valid[1] = 1'b1;
        b_in_data[63:32] = 32'h66;
        #1;
        chk("fts.data", b_out_data, 32'h66);
        chk("fts.ch", 32'(b_out_ch), 1);
        step();
        b_in_valid = '0;
        #1;
        chk("fts.usage1", bu(1), 1);
        chk("fts.mem", b_out_data, 32'h66);
        chk("fts.ch2", 32'(b_out_ch), 1);
        b_out_ready = 1'b1;
        step();
        #1;
        chk("fts.drain", bu(1), 0);
        b_out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
